// File: rtl/ula_seq_if.sv
// Nibble input and result output handshake bundle for ula_seq.
// master: upstream/downstream side; slave: ula_seq side.
interface ula_seq_if;
  logic [3:0] din;
  logic       din_valid;
  logic       din_ready;
  logic [3:0] res;
  logic       res_valid;
  logic       res_ready;
  logic       err;

  modport master (
    output din, din_valid, res_ready,
    input  din_ready, res, res_valid, err
  );

  modport slave (
    input  din, din_valid, res_ready,
    output din_ready, res, res_valid, err
  );
endinterface

// File: rtl/ula_seq.sv
// ula_seq: loads A, B, opcode nibbles, captures ALU result, holds it
// until accepted and counts delivered results.
// Ports: clk, rst_n (async low); bus (slave: din/din_valid/din_ready,
// res/res_valid/res_ready/err); A, B, op to ALU; alu_out from ALU;
// op_count (CNT_W). Macro ULA_DIVZERO_EN adds divide-by-zero flagging.
module ula_seq #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  ula_seq_if.slave         bus,
  output logic [3:0]       A,
  output logic [3:0]       B,
  output logic [2:0]       op,
  input  logic [3:0]       alu_out,
  output logic [CNT_W-1:0] op_count
);

  typedef enum logic [2:0] {
    GET_A, GET_B, GET_OP, EXEC, HOLD
  } state_t;

  state_t           state_q, state_d;
  logic [3:0]       a_q, a_d;
  logic [3:0]       b_q, b_d;
  logic [2:0]       op_q, op_d;
  logic [3:0]       res_q, res_d;
  logic             res_valid_q, res_valid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             din_ready_c;
`ifdef ULA_DIVZERO_EN
  logic             err_q, err_d;
`endif

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    op_d        = op_q;
    res_d       = res_q;
    res_valid_d = res_valid_q;
    cnt_d       = cnt_q;
    din_ready_c = 1'b0;
`ifdef ULA_DIVZERO_EN
    err_d       = err_q;
`endif
    unique case (state_q)
      GET_A: begin
        din_ready_c = 1'b1;
        if (bus.din_valid) begin
          a_d     = bus.din;
          state_d = GET_B;
        end
      end
      GET_B: begin
        din_ready_c = 1'b1;
        if (bus.din_valid) begin
          b_d     = bus.din;
          state_d = GET_OP;
        end
      end
      GET_OP: begin
        din_ready_c = 1'b1;
        if (bus.din_valid) begin
          op_d    = bus.din[2:0];
          state_d = EXEC;
        end
      end
      EXEC: begin
`ifdef ULA_DIVZERO_EN
        if (op_q == 3'b011 && b_q == 4'h0) begin
          res_d = 4'hF;
          err_d = 1'b1;
        end else begin
          res_d = alu_out;
          err_d = 1'b0;
        end
`else
        res_d = alu_out;
`endif
        res_valid_d = 1'b1;
        state_d     = HOLD;
      end
      HOLD: begin
        if (bus.res_ready) begin
          res_valid_d = 1'b0;
          cnt_d       = cnt_q + CNT_W'(1);
          state_d     = GET_A;
        end
      end
      default: state_d = GET_A;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= GET_A;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= '0;
      res_q       <= '0;
      res_valid_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      op_q        <= op_d;
      res_q       <= res_d;
      res_valid_q <= res_valid_d;
      cnt_q       <= cnt_d;
    end
  end

`ifdef ULA_DIVZERO_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= err_d;
  end
  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif

  assign bus.din_ready = din_ready_c;
  assign bus.res       = res_q;
  assign bus.res_valid = res_valid_q;
  assign A             = a_q;
  assign B             = b_q;
  assign op            = op_q;
  assign op_count      = cnt_q;

endmodule
